// File: rtl/rx_bit_packer_pkg.sv
// Shared OFDM RX definitions: dibit/byte widths and the byte FIFO entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rx_bit_packer_pkg;

    localparam int DIBIT_W         = 2;
    localparam int BYTE_W          = 8;
    localparam int DIBITS_PER_BYTE = BYTE_W / DIBIT_W;

    // One FIFO slot: a packed byte plus its end-of-symbol marker.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO with synchronous flush.
// Latency: a push is visible at head one cycle later; the head is combinational from storage.
// Backpressure: push to a full FIFO is ignored unless a pop happens in the same cycle.
//
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   flush              synchronous clear of both pointers (wins over push/pop)
//   push, push_entry   write request and record
//   pop                read request (ignored when empty)
//   head               record at the read pointer, zero when empty
//   full, empty        occupancy flags
module rx_byte_fifo
    import rx_bit_packer_pkg::*;
#(
    parameter int depth_g = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(depth_g);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fifo_entry_t mem [depth_g];

    logic wr_en;
    logic rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_en = pop & ~empty & ~flush;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en) & ~flush;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // Forcing zero when empty keeps the outputs clean straight out of reset.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rx_bit_packer.sv
// Packs OFDM RX dibits MSB-first into bytes, tags the last byte of each symbol, buffers in a FWFT FIFO.
// Latency: 1 cycle from the edge accepting the 4th dibit to byte_valid (empty FIFO).
// Backpressure: none on the input; bytes arriving at a full FIFO without a pop are dropped and flagged.
//
// Ports:
//   sys_clk, sys_rst, sys_init           clock, async active-high reset, synchronous flush
//   rx_rcv_data, rx_rcv_data_valid       dibit stream from the demodulator
//   byte_data, byte_last, byte_valid     FIFO head
//   byte_ready                           consumer pops the head
//   overflow                             sticky drop flag
//   symbol_count                         completed symbols written into the FIFO (wraps)
module rx_bit_packer
    import rx_bit_packer_pkg::*;
#(
    parameter int raw_symbol_length_g = 160,
    parameter int fifo_depth_g        = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               sys_init,
    input  logic [DIBIT_W-1:0] rx_rcv_data,
    input  logic               rx_rcv_data_valid,
    output logic [BYTE_W-1:0]  byte_data,
    output logic               byte_last,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               overflow,
    output logic [15:0]        symbol_count
);

    localparam int                    BIT_CNT_W      = $clog2(raw_symbol_length_g);
    localparam logic [BIT_CNT_W-1:0]  BIT_CNT_LAST   = BIT_CNT_W'(raw_symbol_length_g - DIBIT_W);
    localparam logic [1:0]            DIBIT_CNT_LAST = 2'(DIBITS_PER_BYTE - 1);

    logic [1:0]                 dibit_cnt;
    logic [BIT_CNT_W-1:0]       bit_cnt;
    logic [BYTE_W-DIBIT_W-1:0]  partial;

    logic        accept;
    logic        byte_done;
    logic        sym_done;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_ok;
    logic        dropped;
    fifo_entry_t push_entry;
    fifo_entry_t head;

    // A flush cycle discards the dibit presented with it.
    assign accept    = rx_rcv_data_valid & ~sys_init;
    assign byte_done = accept & (dibit_cnt == DIBIT_CNT_LAST);
    assign sym_done  = accept & (bit_cnt == BIT_CNT_LAST);

    // The 4th dibit goes straight into the record, so the byte lands in the FIFO on its own edge.
    assign push_entry.data = {partial, rx_rcv_data};
    assign push_entry.last = sym_done;

    assign pop     = byte_valid & byte_ready & ~sys_init;
    assign push_ok = byte_done & (~fifo_full | pop);
    assign dropped = byte_done & fifo_full & ~pop;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dibit_cnt    <= '0;
            bit_cnt      <= '0;
            partial      <= '0;
            overflow     <= 1'b0;
            symbol_count <= '0;
        end else if (sys_init) begin
            dibit_cnt    <= '0;
            bit_cnt      <= '0;
            partial      <= '0;
            overflow     <= 1'b0;
            symbol_count <= '0;
        end else begin
            if (accept) begin
                partial   <= {partial[BYTE_W-2*DIBIT_W-1:0], rx_rcv_data};
                dibit_cnt <= dibit_cnt + 2'd1;
                // Counters keep running through drops so symbol alignment survives overflow.
                bit_cnt   <= sym_done ? '0 : bit_cnt + BIT_CNT_W'(DIBIT_W);
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
            if (push_ok && push_entry.last) begin
                symbol_count <= symbol_count + 16'd1;
            end
        end
    end

    rx_byte_fifo #(
        .depth_g (fifo_depth_g)
    ) u_fifo (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .flush      (sys_init),
        .push       (byte_done),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign byte_valid = ~fifo_empty;
    assign byte_data  = head.data;
    assign byte_last  = head.last;

endmodule

// File: tb/tb_rx_bit_packer.sv
// Directed bench for rx_bit_packer with a queue-based reference model and per-cycle compare.
// Latency: n/a.
// Backpressure: byte_ready driven by the stimulus.
module tb_rx_bit_packer;

    localparam int RAW   = 160;
    localparam int DEPTH = 8;

    logic        sys_clk;
    logic        sys_rst;
    logic        sys_init;
    logic [1:0]  rx_rcv_data;
    logic        rx_rcv_data_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_valid;
    logic        byte_ready;
    logic        overflow;
    logic [15:0] symbol_count;

    rx_bit_packer #(
        .raw_symbol_length_g (RAW),
        .fifo_depth_g        (DEPTH)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .sys_init          (sys_init),
        .rx_rcv_data       (rx_rcv_data),
        .rx_rcv_data_valid (rx_rcv_data_valid),
        .byte_data         (byte_data),
        .byte_last         (byte_last),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .overflow          (overflow),
        .symbol_count      (symbol_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect dibits in fours, count dibits per symbol, hold bytes in a bounded queue.
    logic [1:0]  m_dibits[$];
    int          m_sym_dibits = 0;
    logic [8:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [8:0]  m_nb;
    bit          m_have;
    bit          m_pop;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst || sys_init) begin
            m_dibits.delete();
            m_q.delete();
            m_sym_dibits = 0;
            m_ovf        = 1'b0;
            m_cnt        = '0;
        end else begin
            m_pop  = (m_q.size() != 0) && byte_ready;
            m_have = 1'b0;
            if (rx_rcv_data_valid) begin
                m_dibits.push_back(rx_rcv_data);
                m_sym_dibits++;
                if (m_dibits.size() == 4) begin
                    m_nb   = {m_dibits[0], m_dibits[1], m_dibits[2], m_dibits[3], 1'b0};
                    m_nb[0] = (m_sym_dibits == RAW / 2);
                    if (m_nb[0]) m_sym_dibits = 0;
                    m_dibits.delete();
                    m_have = 1'b1;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_have) begin
                if (m_q.size() >= DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    m_q.push_back(m_nb);
                    if (m_nb[0]) m_cnt = m_cnt + 16'd1;
                end
            end
        end
    end

    // Log of bytes the consumer actually took, for the literal expectations.
    logic [8:0] pop_log[$];
    always @(posedge sys_clk) begin
        if (!sys_rst && !sys_init && byte_valid && byte_ready)
            pop_log.push_back({byte_data, byte_last});
    end

    always @(negedge sys_clk) begin
        if (!done) begin
            chk("cmp_valid", byte_valid, m_q.size() != 0);
            if (byte_valid && m_q.size() != 0) begin
                chk("cmp_data", byte_data, m_q[0][8:1]);
                chk("cmp_last", byte_last, m_q[0][0]);
            end
            chk("cmp_overflow", overflow, m_ovf);
            chk("cmp_symcnt", symbol_count, m_cnt);
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic dibit(input logic [1:0] d);
        rx_rcv_data       = d;
        rx_rcv_data_valid = 1'b1;
        @(negedge sys_clk);
        rx_rcv_data_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        dibit(b[7:6]);
        dibit(b[5:4]);
        dibit(b[3:2]);
        dibit(b[1:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_init();
        sys_init = 1'b1;
        @(negedge sys_clk);
        sys_init = 1'b0;
    endtask

    initial begin
        sys_rst           = 1'b1;
        sys_init          = 1'b0;
        rx_rcv_data       = 2'd0;
        rx_rcv_data_valid = 1'b0;
        byte_ready        = 1'b0;

        @(negedge sys_clk);
        chk("rst_valid", byte_valid, 0);
        chk("rst_data", byte_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_symcnt", symbol_count, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // 11,00,10,01 -> 0xC9 visible for exactly one cycle.
        byte_ready = 1'b1;
        dibit(2'd3); dibit(2'd0); dibit(2'd2);
        chk("c9_not_early", byte_valid, 0);
        dibit(2'd1);
        chk("c9_valid", byte_valid, 1);
        chk("c9_data", byte_data, 8'hC9);
        @(negedge sys_clk);
        chk("c9_one_cycle", byte_valid, 0);

        // One full symbol of sparse dibits i mod 4 -> 20 x 0x1B, last on byte 20.
        do_init();
        pop_log.delete();
        for (int i = 0; i < 80; i++) begin
            dibit(2'(i % 4));
            idle(24);
        end
        chk("sym_nbytes", pop_log.size(), 20);
        for (int i = 0; i < 20 && i < pop_log.size(); i++) begin
            chk("sym_data", pop_log[i][8:1], 8'h1B);
            chk("sym_last", pop_log[i][0], (i == 19));
        end
        chk("sym_count", symbol_count, 1);

        // Nine bytes into a stalled FIFO: eight kept, overflow set.
        do_init();
        byte_ready = 1'b0;
        for (int k = 1; k <= 9; k++) send_byte(8'(16 + k));
        idle(1);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", byte_data, 8'h11);
        pop_log.delete();
        byte_ready = 1'b1;
        idle(12);
        byte_ready = 1'b0;
        chk("ovf_drain_n", pop_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            chk("ovf_drain_data", pop_log[i][8:1], 8'(17 + i));
        chk("ovf_empty", byte_valid, 0);

        // Full FIFO, byte completes with a simultaneous pop: accepted, no overflow.
        do_init();
        for (int k = 0; k < 8; k++) send_byte(8'(32 + k));
        dibit(2'd0); dibit(2'd2); dibit(2'd2);
        byte_ready = 1'b1;
        dibit(2'd1);
        byte_ready = 1'b0;
        chk("full_pop_ovf", overflow, 0);
        chk("full_pop_head", byte_data, 8'h21);
        send_byte(8'h2A);
        chk("full_still_full", overflow, 1);
        pop_log.delete();
        byte_ready = 1'b1;
        idle(12);
        chk("full_drain_n", pop_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            chk("full_drain_data", pop_log[i][8:1], (i < 7) ? 8'(33 + i) : 8'h29);

        // Flush after two dibits (a third presented with it is discarded).
        dibit(2'd3); dibit(2'd3);
        rx_rcv_data       = 2'd2;
        rx_rcv_data_valid = 1'b1;
        sys_init          = 1'b1;
        @(negedge sys_clk);
        rx_rcv_data_valid = 1'b0;
        sys_init          = 1'b0;
        chk("init_ovf_clr", overflow, 0);
        byte_ready = 1'b0;
        dibit(2'd1); dibit(2'd1); dibit(2'd1); dibit(2'd1);
        chk("init_valid", byte_valid, 1);
        chk("init_data", byte_data, 8'h55);

        // Asynchronous reset mid-byte with a full FIFO, overflow and a nonzero count.
        byte_ready = 1'b1;
        for (int k = 0; k < 20; k++) send_byte(8'(176 + k));
        byte_ready = 1'b0;
        for (int k = 0; k < 9; k++) send_byte(8'(208 + k));
        dibit(2'd3); dibit(2'd1);
        chk("pre_rst_ovf", overflow, 1);
        chk("pre_rst_symcnt", symbol_count, 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_valid", byte_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_data", byte_data, 0);
        chk("arst_last", byte_last, 0);
        chk("arst_symcnt", symbol_count, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        byte_ready = 1'b1;
        send_byte(8'hA7);
        chk("post_rst_valid", byte_valid, 1);
        chk("post_rst_data", byte_data, 8'hA7);
        idle(3);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_bit_packer.md
RX_BIT_PACKER -- requirements
Module: rx_bit_packer

Interface
REQ-001 SHALL have parameter raw_symbol_length_g, default 160: bits per OFDM symbol; multiple of 8.
REQ-002 SHALL have parameter fifo_depth_g, default 8: output FIFO depth in bytes; power of two, 2..64.
REQ-003 SHALL have port sys_clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port sys_init  in  1  synchronous flush, same meaning as on the RX path.
REQ-006 SHALL have port rx_rcv_data  in  2  demodulated dibit from the OFDM RX path.
REQ-007 SHALL have port rx_rcv_data_valid  in  1  single-cycle qualifier for rx_rcv_data; there is no backpressure.
REQ-008 SHALL have port byte_data  out  8  packed byte at the FIFO head.
REQ-009 SHALL have port byte_last  out  1  marks the final byte of one OFDM symbol.
REQ-010 SHALL have port byte_valid  out  1  FIFO head holds a byte.
REQ-011 SHALL have port byte_ready  in  1  consumer accepts the head byte.
REQ-012 SHALL have port overflow  out  1  sticky flag: at least one byte was dropped.
REQ-013 SHALL have port symbol_count  out  16  number of completed symbols written into the FIFO.

Function
REQ-014 SHALL pack dibits MSB-first in time: 1st dibit goes to bits [7:6], 4th dibit to bits [1:0].
REQ-015 SHALL keep a 2-bit dibit counter (0..3) and a bit counter (0..raw_symbol_length_g-2, step 2), advanced only on rx_rcv_data_valid.
REQ-016 SHALL push the completed byte into the FIFO in the cycle after the 4th dibit is accepted.
  - byte_last=1 iff that byte closes raw_symbol_length_g bits.
  - The bit counter SHALL then wrap to 0.
REQ-017 SHALL increment symbol_count when a byte_last byte is written; wraps 0xFFFF->0; a dropped last byte SHALL NOT count.
REQ-018 SHALL use a first-word-fall-through FIFO.
  - byte_valid = not empty.
  - byte_data/byte_last are valid whenever byte_valid=1.
  - A pop occurs on byte_valid&byte_ready.
REQ-019 SHALL give a latency of 1 cycle from the 4th dibit's valid edge to byte_valid when the FIFO was empty.
REQ-020 SHALL accept a push to a full FIFO if a pop occurs in the same cycle; occupancy is unchanged and there is no overflow.
REQ-021 SHALL drop the byte on a push to a full FIFO without a pop.
  - overflow SHALL be set and stay set until reset or sys_init.
  - Packing counters SHALL continue so symbol alignment is preserved.
REQ-022 SHALL ignore byte_ready when byte_valid=0; a pop from an empty FIFO has no effect.
REQ-023 SHALL, on sys_init=1, do the following on the next edge:
  - Clear the dibit/bit counters, the partial byte, the FIFO pointers, overflow and symbol_count.
  - Discard any dibit valid in the same cycle.
  - Ignore a pop requested in that cycle.
REQ-024 SHALL hold byte_data/byte_last stable while byte_valid=1 and byte_ready=0.

Reset
REQ-025 SHALL, on sys_rst=1, immediately force byte_valid=0, byte_data=0, byte_last=0, overflow=0 and symbol_count=0, and clear all counters and FIFO pointers.
REQ-026 SHALL resume operation on the first sys_clk edge after sys_rst deasserts; the first accepted dibit is the MSB dibit.

Structure
REQ-027 SHALL take dibit width (2), byte width (8) and a FIFO entry record/type {data[7:0], last} from the shared OFDM RX package.
REQ-028 SHALL implement the FIFO as sub-module rx_byte_fifo (depth generic, push/pop/flush, full/empty); rx_bit_packer holds the packer, counters and flags.

Verification
REQ-029 SHALL cover: ready=1; dibits 11,00,10,01 -> byte_data=0xC9, byte_valid high for exactly 1 cycle, 1 cycle after the 4th dibit.
REQ-030 SHALL cover: 80 dibits with dibit value (i mod 4), spaced every 25 clocks -> 20 bytes of 0x1B, byte_last only on byte 20, symbol_count=1.
REQ-031 SHALL cover: ready=0; 9 bytes fed -> 8 stored, overflow=1; then ready=1 -> 8 bytes drain in order, 9th absent.
REQ-032 SHALL cover: full FIFO; a byte completes while ready=1 -> no overflow, occupancy stays 8, new byte appears last.
REQ-033 SHALL cover: sys_init after 2 dibits -> partial byte discarded; next 4 dibits 01,01,01,01 -> 0x55.
REQ-034 SHALL cover: sys_rst asserted mid-byte with a non-empty FIFO -> byte_valid=0 and overflow=0 without waiting for a clock edge; stream restarts cleanly after release.
